ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, frame watchdog limit in clk cycles (15 ms at 50 MHz).
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port clr  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk  in  1  PS/2 clock line as read back from the pad.
REQ-006 SHALL have port ps2_data  in  1  PS/2 data line as read back from the pad.
REQ-007 SHALL have port ps2_clk_oe  out  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-008 SHALL have port ps2_data_oe  out  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-009 SHALL have port din  in  8  command byte to send to the device.
REQ-010 SHALL have port send  in  1  start request, sampled only in IDLE.
REQ-011 SHALL have port busy  out  1  high from accepted send until done.
REQ-012 SHALL have port done  out  1  one-cycle pulse at frame end.
REQ-013 SHALL have port ack_err  out  1  valid with done; 1 = device did not acknowledge.
REQ-014 SHALL have port timeout_err  out  1  valid with done; 1 = watchdog expired.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 3-flop synchronizer; a falling edge is old-high/new-low of the synchronized clock.
REQ-016 In IDLE with send=1, SHALL latch din, compute odd parity (~^din), assert busy next cycle, and enter INHIBIT.
REQ-017 send while busy SHALL be ignored; din changes after acceptance SHALL have no effect.
REQ-018 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle, then SEND with ps2_clk_oe=0 and ps2_data_oe held at 1 (start bit).
REQ-020 SEND: on falling edges 1-8 SHALL drive din[0]..din[7] (ps2_data_oe = ~bit), on edge 9 parity, on edge 10 release data (stop).
REQ-021 On falling edge 11 SHALL sample synchronized ps2_data: 0 = ACK, 1 = ack_err; then enter WAIT_IDLE.
REQ-022 WAIT_IDLE: when both synchronized lines are high, SHALL pulse done one cycle, drop busy the same cycle, and return to IDLE.
REQ-023 ack_err and timeout_err SHALL hold their value from done until the next accepted send, which clears both.
REQ-024 A 4-bit edge counter SHALL count 0-11 and be cleared on entry to INHIBIT.
REQ-025 ps2_clk_oe and ps2_data_oe SHALL be registered outputs free of glitches.
REQ-026 States SHALL be exactly IDLE, INHIBIT, REQ, SEND, WAIT_IDLE.

Reset
REQ-027 While clr=1: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0, timeout_err=0, and all counters and synchronizers at zero/high-idle.
REQ-028 Reset mid-frame SHALL release both lines immediately (asynchronously) with no done pulse.

Configuration
REQ-029 With PS2_TX_TIMEOUT_EN defined, a counter SHALL start on entry to SEND; reaching TIMEOUT_CYCLES before done SHALL release both lines, pulse done with timeout_err=1, and return to IDLE.
REQ-030 Without PS2_TX_TIMEOUT_EN, no watchdog logic SHALL exist, timeout_err SHALL be tied 0, and SEND/WAIT_IDLE SHALL wait indefinitely.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the state typedef, the frame length constant (11 edges), and the odd-parity function, for reuse by the keyboard receiver.
REQ-032 A sub-module ps2_sync (3-flop synchronizer plus falling-edge detect) SHALL be instantiated once per line.

Verification
REQ-033 Send 0xED with device model ACKing -> data bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; done with ack_err=0.
REQ-034 Send 0xF4 -> parity bit 0; ps2_clk_oe low for exactly INHIBIT_CYCLES+1 cycles; REQ cycle has both oe=1.
REQ-035 Device holds data high on edge 11 -> done with ack_err=1, timeout_err=0.
REQ-036 Second send pulse during SEND with din=0x00 -> ignored; original byte transmitted unchanged.
REQ-037 PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=1000, device never clocks -> done at cycle 1000 after SEND entry, timeout_err=1, both oe=0.
REQ-038 clr asserted after edge 5 -> both oe=0 in the same cycle, busy=0, no done; the next send completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state type, frame constants and the parity helper.
// Shared by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_IDLE
  } ps2_state_e;

  localparam int unsigned FRAME_EDGES = 11;
  localparam int unsigned DATA_BITS   = 8;

  localparam logic [3:0] STOP_EDGE = 4'd10;
  localparam logic [3:0] ACK_EDGE  = 4'(FRAME_EDGES);

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// ps2_sync: 3-flop synchronizer for one PS/2 pad line plus falling-edge detect.
// Resets to the idle-high level so no spurious edge appears after reset.
module ps2_sync (
  input  logic clk,
  input  logic clr,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic [2:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[1:0], line_in};
    prev_d = sync_q[2];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= 3'b111;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q[2];
  assign fall      = prev_q & ~sync_q[2];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-edge frame).
// Optional frame watchdog is built only when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] din,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  // Line index 0 is the clock, 1 is the data line.
  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic [1:0] line_fall;
  logic       clk_sync;
  logic       data_sync;
  logic       clk_fall;
  logic       unused_data_fall;

  assign line_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      ps2_sync u_sync (
        .clk      (clk),
        .clr      (clr),
        .line_in  (line_raw[gi]),
        .line_sync(line_sync[gi]),
        .fall     (line_fall[gi])
      );
    end
  endgenerate

  assign clk_sync         = line_sync[0];
  assign data_sync        = line_sync[1];
  assign clk_fall         = line_fall[0];
  assign unused_data_fall = line_fall[1];

  ps2_state_e           state_q, state_d;
  logic [3:0]           edge_cnt_q, edge_cnt_d;
  logic [3:0]           edge_next;
  logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
  logic [DATA_BITS:0]   tx_q, tx_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ack_err_q, ack_err_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_err_q, timeout_err_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign edge_next = edge_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    tx_d       = tx_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (send) begin
          tx_d       = {odd_parity(din), din};
          busy_d     = 1'b1;
          ack_err_d  = 1'b0;
          edge_cnt_d = 4'd0;
          inh_cnt_d  = '0;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          state_d    = INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      // Releasing the clock with data still low presents the start bit.
      REQ: begin
        clk_oe_d = 1'b0;
        state_d  = SEND;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d = '0;
`endif
      end

      SEND: begin
        if (clk_fall) begin
          edge_cnt_d = edge_next;
          if (edge_next == ACK_EDGE) begin
            ack_err_d = data_sync;
            state_d   = WAIT_IDLE;
          end else if (edge_next == STOP_EDGE) begin
            data_oe_d = 1'b0;
          end else begin
            // Data bits LSB first, then parity, shifted out of tx_q.
            data_oe_d = ~tx_q[0];
            tx_d      = {1'b0, tx_q[DATA_BITS:1]};
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // A normal completion in the same cycle takes priority over the watchdog.
    if ((state_q == SEND || state_q == WAIT_IDLE) && !done_d) begin
      if (wd_q == WD_LAST) begin
        clk_oe_d      = 1'b0;
        data_oe_d     = 1'b0;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        timeout_err_d = 1'b1;
        state_d       = IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      edge_cnt_q <= 4'd0;
      inh_cnt_q  <= '0;
      tx_q       <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      tx_q       <= tx_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model driven inline.
// The watchdog step runs only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 1000;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] din;
  logic       send, busy, done, ack_err, timeout_err;
  logic       dev_clk, dev_data;
  logic [10:0] bits;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         lat;
  int         cnt;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device
  assign ps2_clk  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .din        (din),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    int n;
    din  = b;
    send = 1'b1;
    tick();
    send = 1'b0;
    din  = ~b;
    $display("send 0x%02h accepted", b);
    check("busy_after_accept", busy, 1);
    check("ack_err_cleared", ack_err, 0);
    check("timeout_err_cleared", timeout_err, 0);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < int'(INH) + 10) begin
      n++;
      tick();
    end
    check("inhibit_len", n, INH);
    check("req_clk_oe", ps2_clk_oe, 1);
    check("req_data_oe", ps2_data_oe, 1);
    tick();
    check("start_clk_oe", ps2_clk_oe, 0);
    check("start_data_oe", ps2_data_oe, 1);
  endtask

  task automatic run_frame(input int inject_at, input int abort_at, input logic ack,
                           output logic [10:0] seen);
    seen = '0;
    repeat (10) tick();
    seen[0] = ps2_data;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data = 1'b0;
        repeat (5) tick();
      end
      dev_clk = 1'b0;
      for (int t = 0; t < HALF; t++) begin
        if (k == inject_at && t == 2) begin
          din  = 8'h00;
          send = 1'b1;
        end
        tick();
        send = 1'b0;
      end
      if (k <= 10) seen[k] = ps2_data;
      if (k == abort_at) return;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      else repeat (HALF) tick();
    end
  endtask

  task automatic finish_frame(input logic exp_ack, input logic exp_to, input int bound,
                              output int latency);
    latency = 0;
    while (!done && latency < bound) begin
      tick();
      latency++;
    end
    $display("frame done after %0d cycles: ack_err=%0b timeout_err=%0b", latency, ack_err, timeout_err);
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("ack_err", ack_err, exp_ack);
    check("timeout_err", timeout_err, exp_to);
    check("clk_oe_at_done", ps2_clk_oe, 0);
    check("data_oe_at_done", ps2_data_oe, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("ack_err_hold", ack_err, exp_ack);
  endtask

  initial begin
    clr      = 1'b1;
    send     = 1'b0;
    din      = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    clr = 1'b0;
    tick();

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    start_frame(8'hED);
    run_frame(0, 0, 1'b1, bits);
    $display("frame bits 0x%03h", bits);
    check("bits_ED", bits, 11'h7DA);
    finish_frame(1'b0, 1'b0, 200, lat);

    // 0xF4: parity 0
    start_frame(8'hF4);
    run_frame(0, 0, 1'b1, bits);
    $display("frame bits 0x%03h", bits);
    check("bits_F4", bits, 11'h5E8);
    check("parity_F4", bits[9], 0);
    finish_frame(1'b0, 1'b0, 200, lat);

    // Device withholds ACK
    start_frame(8'h00);
    run_frame(0, 0, 1'b0, bits);
    check("bits_00", bits, 11'h600);
    finish_frame(1'b1, 1'b0, 200, lat);
    repeat (5) tick();
    check("ack_err_held_idle", ack_err, 1);

    // Second send with din=0 during SEND is ignored
    start_frame(8'h3C);
    run_frame(3, 0, 1'b1, bits);
    $display("frame bits 0x%03h", bits);
    check("bits_3C_inject", bits, 11'h678);
    finish_frame(1'b0, 1'b0, 200, lat);

    // Reset after edge 5 while data is being driven low (0x45 bit4 = 0)
    start_frame(8'h45);
    run_frame(0, 5, 1'b1, bits);
    check("abort_data_oe_before", ps2_data_oe, 1);
    clr = 1'b1;
    #1;
    $display("clr asserted mid-frame");
    check("abort_clk_oe", ps2_clk_oe, 0);
    check("abort_data_oe", ps2_data_oe, 0);
    check("abort_busy", busy, 0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick();
    tick();
    check("abort_done_in_reset", done, 0);
    clr = 1'b0;
    cnt = 0;
    repeat (40) begin
      tick();
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    start_frame(8'hAA);
    run_frame(0, 0, 1'b1, bits);
    $display("frame bits 0x%03h", bits);
    check("bits_AA_after_abort", bits, 11'h754);
    finish_frame(1'b0, 1'b0, 200, lat);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: watchdog fires TIMEOUT_CYCLES after SEND entry
    start_frame(8'h12);
    finish_frame(1'b0, 1'b1, int'(TMO) + 100, lat);
    check("timeout_latency", lat, TMO);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
